bcd_counter_2dig: RTL and testbench

- Two-digit BCD up/down counter with debounced pushbutton inputs.
- Produces the 8-bit packed BCD word {tens, ones} consumed by the dual seven-segment decoder stage, in place of the raw switch bus.
- Step, load and wrap events are all registered, so the display stage always sees a valid, glitch-free 00..99 value.

---
 rtl/bcd_counter_2dig.sv | 239 +++++++++++++++++++++++
 tb/tb_bcd_counter_2dig.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_2dig.sv
// bcd_counter_2dig: two-digit BCD up/down counter with debounced pushbuttons.
// Output BCD = {tens, ones}, always 00..99; WRAP pulses one cycle on 99<->00.
// Optional macro BCD_COUNTER_AUTO_REPEAT_EN adds hold-to-repeat on UP/DN.

// Per-input debouncer working on an already synchronized level.
module bcd_counter_2dig_debounce #(
  parameter int unsigned CYCLES     = 4
`ifdef BCD_COUNTER_AUTO_REPEAT_EN
  , parameter bit          RPT_EN     = 1'b0
  , parameter int unsigned RPT_DELAY  = 20
  , parameter int unsigned RPT_PERIOD = 5
`endif
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pressed,
  output logic o_pulse
);

  localparam int unsigned   CW       = $clog2(CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    REL_WAIT
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_pulse;

`ifdef BCD_COUNTER_AUTO_REPEAT_EN
  localparam int unsigned   HMAX     = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int unsigned   HW       = $clog2(HMAX + 1);
  localparam logic [HW-1:0] DLY_LAST = HW'(RPT_DELAY - 1);
  localparam logic [HW-1:0] PER_LAST = HW'(RPT_PERIOD - 1);

  logic [HW-1:0] r_hold;
  logic          r_rep;
`endif

  // Debounce FSM; the step pulse is registered, giving a fixed press-to-count latency.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
`ifdef BCD_COUNTER_AUTO_REPEAT_EN
      r_hold  <= '0;
      r_rep   <= 1'b0;
`endif
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_pressed) begin
            r_state <= PRESS_WAIT;
            r_cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!i_pressed) begin
            r_state <= IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= PRESSED;
            r_pulse <= 1'b1;
`ifdef BCD_COUNTER_AUTO_REPEAT_EN
            r_hold  <= '0;
            r_rep   <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!i_pressed) begin
            r_state <= REL_WAIT;
            r_cnt   <= '0;
`ifdef BCD_COUNTER_AUTO_REPEAT_EN
            r_hold  <= '0;
            r_rep   <= 1'b0;
`endif
          end
`ifdef BCD_COUNTER_AUTO_REPEAT_EN
          // First repeat after RPT_DELAY cycles, then every RPT_PERIOD cycles.
          else if (RPT_EN) begin
            if (r_hold == (r_rep ? PER_LAST : DLY_LAST)) begin
              r_pulse <= 1'b1;
              r_hold  <= '0;
              r_rep   <= 1'b1;
            end else begin
              r_hold <= r_hold + 1'b1;
            end
          end
`endif
        end
        REL_WAIT: begin
          if (i_pressed) begin
            r_state <= PRESSED;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_pulse = r_pulse;

endmodule

module bcd_counter_2dig #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic       CLOCK_50,
  input  logic       RST_N,
  input  logic       KEY_UP_N,
  input  logic       KEY_DN_N,
  input  logic       LOAD_N,
  input  logic [7:0] SW_VAL,
  output logic [7:0] BCD,
  output logic       WRAP
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_PERIOD must be non-zero");
  end

  // Bit order in the synchronizer vectors: [2]=LOAD, [1]=DN, [0]=UP (active-low).
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic       w_up_pulse;
  logic       w_dn_pulse;
  logic       w_ld_pulse;
  logic [7:0] r_bcd;
  logic       r_wrap;

  // Two-flop synchronizers; reset to the released (high) level.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= {LOAD_N, KEY_DN_N, KEY_UP_N};
      r_sync2 <= r_sync1;
    end
  end

`ifdef BCD_COUNTER_AUTO_REPEAT_EN
  bcd_counter_2dig_debounce #(
    .CYCLES(DEBOUNCE_CYCLES), .RPT_EN(1'b1),
    .RPT_DELAY(REPEAT_DELAY), .RPT_PERIOD(REPEAT_PERIOD)
  ) u_db_up (
    .i_clk(CLOCK_50), .i_rst_n(RST_N), .i_pressed(!r_sync2[0]), .o_pulse(w_up_pulse)
  );
  bcd_counter_2dig_debounce #(
    .CYCLES(DEBOUNCE_CYCLES), .RPT_EN(1'b1),
    .RPT_DELAY(REPEAT_DELAY), .RPT_PERIOD(REPEAT_PERIOD)
  ) u_db_dn (
    .i_clk(CLOCK_50), .i_rst_n(RST_N), .i_pressed(!r_sync2[1]), .o_pulse(w_dn_pulse)
  );
  bcd_counter_2dig_debounce #(
    .CYCLES(DEBOUNCE_CYCLES), .RPT_EN(1'b0),
    .RPT_DELAY(REPEAT_DELAY), .RPT_PERIOD(REPEAT_PERIOD)
  ) u_db_ld (
    .i_clk(CLOCK_50), .i_rst_n(RST_N), .i_pressed(!r_sync2[2]), .o_pulse(w_ld_pulse)
  );
`else
  bcd_counter_2dig_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .i_clk(CLOCK_50), .i_rst_n(RST_N), .i_pressed(!r_sync2[0]), .o_pulse(w_up_pulse)
  );
  bcd_counter_2dig_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
    .i_clk(CLOCK_50), .i_rst_n(RST_N), .i_pressed(!r_sync2[1]), .o_pulse(w_dn_pulse)
  );
  bcd_counter_2dig_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_ld (
    .i_clk(CLOCK_50), .i_rst_n(RST_N), .i_pressed(!r_sync2[2]), .o_pulse(w_ld_pulse)
  );
`endif

  function automatic logic [3:0] clamp9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  // Counter: load > up+down cancel > single step; WRAP is a registered one-cycle pulse.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_bcd  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (w_ld_pulse) begin
        r_bcd <= {clamp9(SW_VAL[7:4]), clamp9(SW_VAL[3:0])};
      end else if (w_up_pulse && w_dn_pulse) begin
        r_bcd <= r_bcd;
      end else if (w_up_pulse) begin
        if (r_bcd[3:0] == 4'd9) begin
          r_bcd[3:0] <= 4'd0;
          if (r_bcd[7:4] == 4'd9) begin
            r_bcd[7:4] <= 4'd0;
            r_wrap     <= 1'b1;
          end else begin
            r_bcd[7:4] <= r_bcd[7:4] + 4'd1;
          end
        end else begin
          r_bcd[3:0] <= r_bcd[3:0] + 4'd1;
        end
      end else if (w_dn_pulse) begin
        if (r_bcd[3:0] == 4'd0) begin
          r_bcd[3:0] <= 4'd9;
          if (r_bcd[7:4] == 4'd0) begin
            r_bcd[7:4] <= 4'd9;
            r_wrap     <= 1'b1;
          end else begin
            r_bcd[7:4] <= r_bcd[7:4] - 4'd1;
          end
        end else begin
          r_bcd[3:0] <= r_bcd[3:0] - 4'd1;
        end
      end
    end
  end

  assign BCD  = r_bcd;
  assign WRAP = r_wrap;

endmodule

// File: tb/tb_bcd_counter_2dig.sv
// Testbench for bcd_counter_2dig: table vectors, randomized presses against
// a decimal reference model, and hand sequences for bounce, reset and repeat.
module tb_bcd_counter_2dig;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 5;
`ifdef BCD_COUNTER_AUTO_REPEAT_EN
  localparam int N_RPT = 4;
`else
  localparam int N_RPT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       up_n, dn_n, ld_n;
  logic [7:0] sw;
  logic [7:0] bcd;
  logic       wrap;

  int n_pass  = 0;
  int n_total = 0;
  int model_val = 0;   // counter value as a plain integer 0..99

  always #5 clk = ~clk;

  bcd_counter_2dig #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .CLOCK_50(clk),
    .RST_N(rst_n),
    .KEY_UP_N(up_n),
    .KEY_DN_N(dn_n),
    .LOAD_N(ld_n),
    .SW_VAL(sw),
    .BCD(bcd),
    .WRAP(wrap)
  );

  typedef struct {
    bit         up;
    bit         dn;
    bit         ld;
    logic [7:0] sw;
    int         hold;
    logic [7:0] exp_bcd;
    bit         exp_wrap;
  } vec_t;

  vec_t vecs[19];

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h want %02h", nm, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b", nm, act, exp);
  endtask

  // Reference model: one accepted event, in decimal arithmetic.
  task automatic model_step(input bit up, input bit dn, input bit ld,
                            input logic [7:0] s, output bit w);
    int t, o;
    w = 1'b0;
    if (ld) begin
      t = int'(s[7:4]); o = int'(s[3:0]);
      if (t > 9) t = 9;
      if (o > 9) o = 9;
      model_val = t * 10 + o;
    end else if (up && dn) begin
      model_val = model_val;
    end else if (up) begin
      w = (model_val == 99);
      model_val = (model_val + 1) % 100;
    end else if (dn) begin
      w = (model_val == 0);
      model_val = (model_val + 99) % 100;
    end
  endtask

  // Press the selected keys together for 'hold' sampled cycles; check the
  // value just before and at the expected update edge, and WRAP around it.
  task automatic do_press(input bit up, input bit dn, input bit ld,
                          input logic [7:0] swv, input int hold,
                          input logic [7:0] exp_old, input logic [7:0] exp_new,
                          input bit exp_wrap, input string tag);
    int last;
    sw = swv;
    @(posedge clk); #1;
    up_n = !up; dn_n = !dn; ld_n = !ld;
    last = (hold > 12) ? hold : 12;
    for (int e = 1; e <= last; e++) begin
      @(posedge clk); #1;
      if (e == hold) begin up_n = 1'b1; dn_n = 1'b1; ld_n = 1'b1; end
      if (e == D + 3) begin
        chk8({tag, " bcd_before"}, bcd, exp_old);
        chk1({tag, " wrap_before"}, wrap, 1'b0);
      end
      if (e == D + 4) begin
        chk8({tag, " bcd_after"}, bcd, exp_new);
        chk1({tag, " wrap_at"}, wrap, exp_wrap);
      end
      if (e == D + 5) chk1({tag, " wrap_after"}, wrap, 1'b0);
    end
    repeat (D + 8) @(posedge clk);
  endtask

  initial begin
    logic [7:0] cur, old_b, swv;
    bit         up, dn, ld, w, step;
    int         hold, steps, q;

    vecs[0]  = '{1, 0, 0, 8'h00, 10, 8'h01, 0};
    vecs[1]  = '{1, 0, 0, 8'h00,  3, 8'h01, 0};
    vecs[2]  = '{0, 0, 1, 8'h98, 10, 8'h98, 0};
    vecs[3]  = '{1, 0, 0, 8'h98, 10, 8'h99, 0};
    vecs[4]  = '{1, 0, 0, 8'h98, 10, 8'h00, 1};
    vecs[5]  = '{0, 1, 0, 8'h98, 10, 8'h99, 1};
    vecs[6]  = '{0, 0, 1, 8'hAF, 10, 8'h99, 0};
    vecs[7]  = '{0, 0, 1, 8'h3C, 10, 8'h39, 0};
    vecs[8]  = '{0, 0, 1, 8'h42, 10, 8'h42, 0};
    vecs[9]  = '{1, 1, 0, 8'h42, 10, 8'h42, 0};
    vecs[10] = '{1, 0, 1, 8'h07, 10, 8'h07, 0};
    vecs[11] = '{0, 1, 0, 8'h07, 10, 8'h06, 0};
    vecs[12] = '{0, 0, 1, 8'h90, 10, 8'h90, 0};
    vecs[13] = '{0, 1, 0, 8'h90, 10, 8'h89, 0};
    vecs[14] = '{1, 0, 0, 8'h90, 10, 8'h90, 0};
    vecs[15] = '{0, 0, 1, 8'h00, 10, 8'h00, 0};
    vecs[16] = '{0, 1, 0, 8'h00, 10, 8'h99, 1};
    vecs[17] = '{0, 0, 1, 8'hF5, 10, 8'h95, 0};
    vecs[18] = '{0, 1, 0, 8'h00,  2, 8'h95, 0};

    rst_n = 1'b0; up_n = 1'b1; dn_n = 1'b1; ld_n = 1'b1; sw = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk8("reset bcd", bcd, 8'h00);
    chk1("reset wrap", wrap, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Table vectors
    cur = 8'h00;
    foreach (vecs[i]) begin
      do_press(vecs[i].up, vecs[i].dn, vecs[i].ld, vecs[i].sw, vecs[i].hold,
               cur, vecs[i].exp_bcd, vecs[i].exp_wrap, $sformatf("vec%0d", i));
      cur = vecs[i].exp_bcd;
    end
    model_val = from_bcd(cur);

    // Bounce during release must not add a step
    old_b = to_bcd(model_val);
    model_step(1'b1, 1'b0, 1'b0, 8'h00, w);
    @(posedge clk); #1;
    up_n = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk8("bounce first_step", bcd, to_bcd(model_val));
    up_n = 1'b1; @(posedge clk); #1;
    up_n = 1'b0; @(posedge clk); #1;
    up_n = 1'b1; @(posedge clk); #1;
    up_n = 1'b0; @(posedge clk); #1;
    up_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk8("bounce no_extra", bcd, to_bcd(model_val));

    // Randomized presses against the model (holds avoid the D..D+1 edge)
    for (int it = 0; it < 40; it++) begin
      up   = ($urandom_range(0, 1) == 1);
      dn   = ($urandom_range(0, 1) == 1);
      ld   = ($urandom_range(0, 3) == 0);
      swv  = 8'($urandom);
      hold = ($urandom_range(0, 1) == 1) ? $urandom_range(1, D - 1)
                                         : $urandom_range(D + 2, D + 6);
      step = (hold >= D + 1) && (up || dn || ld);
      old_b = to_bcd(model_val);
      w = 1'b0;
      if (step) model_step(up, dn, ld, swv, w);
      do_press(up, dn, ld, swv, hold, old_b, to_bcd(model_val), w,
               $sformatf("rnd%0d", it));
    end

    // Reset asserted while a key is held; requalification after release
    do_press(1'b0, 1'b0, 1'b1, 8'h55, 10, to_bcd(model_val), 8'h55, 1'b0, "preload55");
    @(posedge clk); #1;
    up_n = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk8("hold step", bcd, 8'h56);
    #3 rst_n = 1'b0;
    #1;
    chk8("midhold reset bcd", bcd, 8'h00);
    chk1("midhold reset wrap", wrap, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int e = 1; e <= D + 4; e++) begin
      @(posedge clk); #1;
      if (e == D + 3) chk8("post_reset before", bcd, 8'h00);
      if (e == D + 4) chk8("post_reset step", bcd, 8'h01);
    end
    repeat (10) @(posedge clk);
    #1;
    chk8("post_reset single", bcd, 8'h01);
    up_n = 1'b1;
    repeat (D + 10) @(posedge clk);
    model_val = 1;

    // Long hold from 00: one step, plus auto-repeat steps when enabled
    do_press(1'b0, 1'b0, 1'b1, 8'h00, 10, to_bcd(model_val), 8'h00, 1'b0, "preload00");
    q = D + 4;
    @(posedge clk); #1;
    up_n = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk); #1;
      if (e == q + RD + 3 * RP - 1) up_n = 1'b1;
      steps = (e >= q) ? 1 : 0;
      for (int j = 0; j < N_RPT; j++)
        if (e >= q + RD + RP * j) steps++;
      chk8($sformatf("hold e%0d", e), bcd, to_bcd(steps));
      chk1($sformatf("hold wrap e%0d", e), wrap, 1'b0);
    end
    model_val = 1 + N_RPT;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
